// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[0..63] for one 512-bit block from 16 input words.
// Latency: W0 is on w_out right after the edge that samples data_load; one word per cycle after that.
// Backpressure: none. Input words are taken every edge; a data_load while busy only raises load_err.
module sha256_msg_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_load,
  input  logic [31:0] data_prepro,
  output logic [31:0] w_out,
  output logic [5:0]  w_idx,
  output logic        w_valid,
  output logic        busy,
  output logic        done,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;

  // 16-deep window: win[0] = W[t-16], win[15] = W[t-1]
  logic [31:0] win [16];

  logic [31:0] w_exp;
  logic [31:0] w_out_nxt;
  logic [5:0]  w_idx_nxt;
  logic        w_valid_nxt;
  logic        done_nxt;
  logic        load_err_nxt;
  logic        shift_en;
  logic [31:0] shift_dat;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Expansion term built from the window taps t-2, t-7, t-15, t-16; wraps mod 2^32.
  always_comb begin
    w_exp = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  // Next-state and next-output decode; outputs fall back to their idle values.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    w_out_nxt    = 32'd0;
    w_idx_nxt    = 6'd0;
    w_valid_nxt  = 1'b0;
    done_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    shift_en     = 1'b0;
    shift_dat    = data_prepro;
    case (state)
      IDLE: begin
        if (data_load) begin
          w_out_nxt   = data_prepro;
          w_idx_nxt   = 6'd0;
          w_valid_nxt = 1'b1;
          shift_en    = 1'b1;
          cnt_nxt     = 6'd1;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        w_out_nxt    = data_prepro;
        w_idx_nxt    = cnt;
        w_valid_nxt  = 1'b1;
        shift_en     = 1'b1;
        load_err_nxt = data_load;
        cnt_nxt      = cnt + 6'd1;
        if (cnt == 6'd15) begin
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_out_nxt    = w_exp;
        w_idx_nxt    = cnt;
        w_valid_nxt  = 1'b1;
        shift_en     = 1'b1;
        shift_dat    = w_exp;
        load_err_nxt = data_load;
        if (cnt == 6'd63) begin
          done_nxt  = 1'b1;
          cnt_nxt   = 6'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 6'd0;
      end
    endcase
  end

  // State and word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Window shift: new word enters at the top, oldest falls off the bottom.
  // Not cleared between blocks since LOAD rewrites all 16 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= 32'd0;
      end
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= shift_dat;
    end
  end

  // Registered outputs; busy mirrors w_valid by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_out    <= 32'd0;
      w_idx    <= 6'd0;
      w_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      w_out    <= w_out_nxt;
      w_idx    <= w_idx_nxt;
      w_valid  <= w_valid_nxt;
      busy     <= w_valid_nxt;
      done     <= done_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule.
// Reference schedule computed with plain arithmetic from the SHA-256 definition.
// Inputs driven on the falling edge, outputs checked on the falling edge.
module tb_sha256_msg_schedule;

  typedef logic [31:0] w16_t [16];
  typedef logic [31:0] w64_t [64];

  logic        clk;
  logic        rst_n;
  logic        data_load;
  logic [31:0] data_prepro;
  logic [31:0] w_out;
  logic [5:0]  w_idx;
  logic        w_valid;
  logic        busy;
  logic        done;
  logic        load_err;

  int   errors = 0;
  int   checks = 0;
  w64_t obs;

  sha256_msg_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_load   (data_load),
    .data_prepro (data_prepro),
    .w_out       (w_out),
    .w_idx       (w_idx),
    .w_valid     (w_valid),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input w16_t m, output w64_t w);
    longint unsigned s;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        w[t] = m[t];
      end else begin
        s = longint'(rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
          + longint'(w[t-7])
          + longint'(rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
          + longint'(w[t-16]);
        w[t] = 32'(s % 64'h1_0000_0000);
      end
    end
  endtask

  // Runs one block. Caller is at a falling edge. If start, data_load/W0 are driven now;
  // otherwise the previous block already drove them. Cycles e1/e2 get a stray data_load.
  // Checking stops after output t=stop_at (64 = whole block).
  task automatic run_block(input w16_t m, input int e1, input int e2, input int stop_at,
                           input bit start, input bit has_next, input logic [31:0] next0,
                           input string name);
    w64_t exp_w;
    logic [41:0] got, want;
    model(m, exp_w);
    if (start) begin
      data_load   = 1'b1;
      data_prepro = m[0];
    end
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      obs[t] = w_out;
      want = {exp_w[t], 6'(t), 1'b1, 1'b1, (t == 63), (t > 0 && ((t - 1) == e1 || (t - 1) == e2))};
      got  = {w_out, w_idx, w_valid, busy, done, load_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s t=%0d: got w=%08h idx=%0d vld=%b busy=%b done=%b err=%b, want w=%08h idx=%0d vld=%b busy=%b done=%b err=%b",
                 name, t, got[41:10], got[9:4], got[3], got[2], got[1], got[0],
                 want[41:10], want[9:4], want[3], want[2], want[1], want[0]);
      end
      if (t == stop_at) return;
      data_prepro = (t < 15) ? m[t+1] : 32'd0;
      data_load   = (t == e1 || t == e2);
      if (t == 63 && has_next) begin
        data_load   = 1'b1;
        data_prepro = next0;
      end
    end
    if (!has_next) begin
      @(negedge clk);
      checks++;
      if ({w_out, w_idx, w_valid, busy, done, load_err} !== 42'd0) begin
        errors++;
        $display("FAIL %s_after_block: got w=%08h idx=%0d vld=%b busy=%b done=%b err=%b, want all 0",
                 name, w_out, w_idx, w_valid, busy, done, load_err);
      end
    end
  endtask

  task automatic rand_block(output w16_t m);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  task automatic test_reset();
    rst_n       = 1'b1;
    data_load   = 1'b0;
    data_prepro = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({w_out, w_idx, w_valid, busy, done, load_err} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: got w=%08h idx=%0d vld=%b busy=%b done=%b err=%b, want all 0",
               w_out, w_idx, w_valid, busy, done, load_err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    w16_t m;
    for (int i = 0; i < 16; i++) m[i] = 32'd0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
    // Load lands on the first edge after reset release.
    run_block(m, -1, -1, 64, 1'b1, 1'b0, 32'd0, "abc");
    checks++;
    if (obs[16] !== 32'h61626380) begin
      errors++;
      $display("FAIL abc_w16: got %08h want 61626380", obs[16]);
    end
    checks++;
    if (obs[17] !== 32'h000F0000) begin
      errors++;
      $display("FAIL abc_w17: got %08h want 000f0000", obs[17]);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({w_valid, busy, done, load_err} !== 4'd0) begin
        errors++;
        $display("FAIL idle cyc=%0d: got vld=%b busy=%b done=%b err=%b want 0000",
                 i, w_valid, busy, done, load_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    w16_t a, b;
    rand_block(a);
    rand_block(b);
    @(negedge clk);
    run_block(a, -1, -1, 64, 1'b1, 1'b1, b[0], "b2b_first");
    run_block(b, -1, -1, 64, 1'b0, 1'b0, 32'd0, "b2b_second");
  endtask

  task automatic test_load_err();
    w16_t m;
    rand_block(m);
    @(negedge clk);
    run_block(m, 5, 40, 64, 1'b1, 1'b0, 32'd0, "load_err");
  endtask

  task automatic test_reset_midblock();
    w16_t a, b;
    rand_block(a);
    rand_block(b);
    @(negedge clk);
    run_block(a, -1, -1, 30, 1'b1, 1'b0, 32'd0, "pre_reset");
    data_load = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if ({w_out, w_idx, w_valid, busy, done, load_err} !== 42'd0) begin
      errors++;
      $display("FAIL midblock_reset: got w=%08h idx=%0d vld=%b busy=%b done=%b err=%b, want all 0",
               w_out, w_idx, w_valid, busy, done, load_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_block(b, -1, -1, 64, 1'b1, 1'b0, 32'd0, "post_reset");
  endtask

  task automatic test_all_ones();
    w16_t m;
    for (int i = 0; i < 16; i++) m[i] = 32'hFFFFFFFF;
    @(negedge clk);
    run_block(m, -1, -1, 64, 1'b1, 1'b0, 32'd0, "all_ones");
  endtask

  task automatic test_random();
    w16_t m;
    for (int k = 0; k < 3; k++) begin
      rand_block(m);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_block(m, -1, -1, 64, 1'b1, 1'b0, 32'd0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_idle();
    test_back_to_back();
    test_load_err();
    test_reset_midblock();
    test_all_ones();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
